rom_arbiter: RTL

Shares the single byte-wide boot ROM port between two requesters: port A (the WASM boot loader) and port B (instruction/data fetch once the ROM has been mapped). Before `rom_mapped` only port A may reach the ROM. After that, A and B are served round-robin, with exactly one ROM read in flight at a time. The block sits between the requesters and the ROM model/controller. It re-times each requester's level-style `read_en`/`ready` handshake onto the shared ROM handshake.

---
 rtl/rom_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Lets two requesters share the single byte-wide boot ROM port:
//   port A - WASM boot loader, always allowed to reach the ROM
//   port B - instruction/data fetch, allowed only once rom_mapped is high
// Once the ROM is mapped, A and B are served round-robin. Only one ROM read is
// in flight at a time. Each transaction runs IDLE -> WAIT -> RESP. RESP is a
// turnaround cycle, so a requester may drop read_en or change its address in
// the cycle after its ready pulse.
//
// Parameters
//   ADDR_W          address width on all ports
//   DATA_W          ROM data width
//   TIMEOUT_CYCLES  WAIT cycles before abort (1..65535, timeout build only)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rom_mapped                 boot complete: enables port B and round-robin
//   a_addr/a_read_en           port A request (level)
//   a_data/a_ready             port A data (held) and one-cycle valid pulse
//   b_addr/b_read_en           port B request (level)
//   b_data/b_ready             port B data (held) and one-cycle valid pulse
//   rom_addr/rom_read_en       shared ROM request
//   rom_data_out/rom_ready     shared ROM response (rom_ready sampled in WAIT)
//   busy                       transaction in progress (state != IDLE)
//   grant_b                    owner of current/last transaction (0 = A)
//   rom_err                    sticky timeout flag
//
// Build option
//   ROM_ARB_TIMEOUT_EN  when defined, a WAIT that lasts TIMEOUT_CYCLES cycles
//                       without rom_ready is aborted. The owner gets all-ones
//                       data and a ready pulse, and rom_err is set (sticky).
//                       When undefined, WAIT lasts until rom_ready and
//                       rom_err is tied to 0.
// -----------------------------------------------------------------------------

// Per-port response register: holds the last returned data and produces the
// one-cycle ready pulse on the cycle after the load.
module rom_arb_port #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data,
  output logic              ready
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      ready <= 1'b0;
    end else begin
      ready <= load;
      if (load) data <= load_data;
    end
  end

endmodule

module rom_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rom_mapped,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_read_en,
  output logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_read_en,
  output logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read_en,
  input  logic [DATA_W-1:0] rom_data_out,
  input  logic              rom_ready,
  output logic              busy,
  output logic              grant_b,
  output logic              rom_err
);

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // Round-robin pointer. It is kept apart from grant_b because it resets to B
  // (so the first contested grant goes to A) while grant_b resets to 0.
  logic last_b;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic elig_a, elig_b, pick_b;

  assign elig_a = a_read_en;
  assign elig_b = b_read_en & rom_mapped;
  // With both eligible, take the port not granted last. Otherwise take
  // whichever port is eligible.
  assign pick_b = elig_b & (~elig_a | ~last_b);

  // ---------------------------------------------------------------------------
  // Completion: normal ROM response, or timeout abort. A rom_ready that
  // coincides with expiry wins, because expire is qualified by ~rom_ready.
  // ---------------------------------------------------------------------------
  logic              expire;
  logic              done;
  logic [DATA_W-1:0] fill;

  assign done = (state == WAIT) & (rom_ready | expire);
  assign fill = rom_ready ? rom_data_out : {DATA_W{1'b1}};

`ifdef ROM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        err_q;

  // wait_cnt counts completed WAIT cycles. It is zero on entry to WAIT.
  assign expire  = (state == WAIT) & ~rom_ready & (wait_cnt == TO_LAST);
  assign rom_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != WAIT)  wait_cnt <= '0;
      else if (!done)     wait_cnt <= wait_cnt + 16'd1;
      if (expire)         err_q    <= 1'b1;
    end
  end
`else
  // Keep the timeout parameter visibly consumed in the plain build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire  = 1'b0;
  assign rom_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Main FSM. Registered ROM request, owner and round-robin pointer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rom_addr    <= '0;
      rom_read_en <= 1'b0;
      grant_b     <= 1'b0;
      last_b      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (elig_a | elig_b) begin
            grant_b     <= pick_b;
            last_b      <= pick_b;
            rom_addr    <= pick_b ? b_addr : a_addr;
            rom_read_en <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // rom_addr holds. Owner address/read_en changes are not tracked.
          if (done) begin
            rom_read_en <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Per-port response registers. Only the owner loads; the other port keeps
  // its data and its ready stays low.
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS-1:0]             load;
  logic [NUM_PORTS-1:0][DATA_W-1:0] port_data;
  logic [NUM_PORTS-1:0]             port_ready;

  assign load = done ? (grant_b ? 2'b10 : 2'b01) : 2'b00;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    rom_arb_port #(.DATA_W(DATA_W)) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[p]),
      .load_data (fill),
      .data      (port_data[p]),
      .ready     (port_ready[p])
    );
  end

  assign a_data  = port_data[0];
  assign a_ready = port_ready[0];
  assign b_data  = port_data[1];
  assign b_ready = port_ready[1];

endmodule
